// File: rtl/unified_buffer_write_control_unit.sv
// unified_buffer_write_control_unit: drains accumulator rows via valid/ready and writes them row-major into the unified buffer
module unified_buffer_write_control_unit #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [6:0]        U_dim1_i,
    input  logic [2:0]        W_tiles1_i,
    input  logic [ADDR_W-1:0] unified_buffer_start_addr_wr_i,
    input  logic              acc_valid_i,
    input  logic [DATA_W-1:0] acc_data_i,
    output logic              acc_ready_o,
    input  logic              ub_wr_stall_i,
    output logic              unified_buffer_write_en_o,
    output logic [ADDR_W-1:0] unified_buffer_addr_wr_o,
    output logic [DATA_W-1:0] unified_buffer_data_wr_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]        state;
    logic [6:0]        u_dim1_q;
    logic [2:0]        w_tiles1_q;
    logic [ADDR_W-1:0] base_q;
    logic [3:0]        stride_q;
    logic [6:0]        row_cnt;
    logic [2:0]        tile_cnt;
    logic [ADDR_W-1:0] row_off;
    logic              beat;
    logic              last_row;
    logic              last_tile;

    assign acc_ready_o = (state == WRITE) & ~ub_wr_stall_i;
    assign busy_o      = state == WRITE;
    assign beat        = acc_valid_i & acc_ready_o;
    assign last_row    = row_cnt == u_dim1_q;
    assign last_tile   = tile_cnt == w_tiles1_q;

    // row_off is the offset from base; it steps by stride per row and reloads to t+1 at a tile boundary
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state                     <= IDLE;
            u_dim1_q                  <= '0;
            w_tiles1_q                <= '0;
            base_q                    <= '0;
            stride_q                  <= '0;
            row_cnt                   <= '0;
            tile_cnt                  <= '0;
            row_off                   <= '0;
            unified_buffer_write_en_o <= 1'b0;
            unified_buffer_addr_wr_o  <= '0;
            unified_buffer_data_wr_o  <= '0;
            done_o                    <= 1'b0;
        end else begin
            unified_buffer_write_en_o <= beat;
            done_o                    <= beat & last_row & last_tile;
            if (state == IDLE) begin
                if (start_i) begin
                    state      <= WRITE;
                    u_dim1_q   <= U_dim1_i;
                    w_tiles1_q <= W_tiles1_i;
                    base_q     <= unified_buffer_start_addr_wr_i;
                    stride_q   <= {1'b0, W_tiles1_i} + 4'd1;
                    row_cnt    <= '0;
                    tile_cnt   <= '0;
                    row_off    <= '0;
                end
            end else if (beat) begin
                unified_buffer_addr_wr_o <= base_q + row_off;
                unified_buffer_data_wr_o <= acc_data_i;
                if (last_row) begin
                    row_cnt  <= '0;
                    tile_cnt <= tile_cnt + 3'd1;
                    row_off  <= ADDR_W'(tile_cnt) + ADDR_W'(1);
                    if (last_tile) state <= IDLE;
                end else begin
                    row_cnt <= row_cnt + 7'd1;
                    row_off <= row_off + ADDR_W'(stride_q);
                end
            end
        end
    end
endmodule

// File: doc/unified_buffer_write_control_unit.md
# unified_buffer_write_control_unit

Write-side controller for the unified buffer. It drains finished output rows from the accumulator through a valid/ready handshake and writes each row into the unified buffer. Rows are stored row-major, so the stored matrix can be fetched as input tiles for the next layer. It is the counterpart of the unified buffer read controller, which feeds input tiles into the systolic array.

## Interface
Parameters:
- DATA_W, 256, width of one unified buffer word (32 lanes x 8 bit).
- ADDR_W, 12, unified buffer address width.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle pulse; latches the configuration and starts a job; only honoured in IDLE.
- U_dim1_i  in  7  output rows per tile minus 1 (1..128 rows).
- W_tiles1_i  in  3  output column tiles minus 1 (1..8 tiles).
- unified_buffer_start_addr_wr_i  in  ADDR_W  base address of the output matrix.
- acc_valid_i  in  1  accumulator presents one output row.
- acc_data_i  in  DATA_W  row payload.
- acc_ready_o  out  1  writer accepts the row this cycle.
- ub_wr_stall_i  in  1  UB write port is taken by the host; no beat is accepted while high.
- unified_buffer_write_en_o  out  1  write strobe.
- unified_buffer_addr_wr_o  out  ADDR_W  write address.
- unified_buffer_data_wr_o  out  DATA_W  write data.
- busy_o  out  1  a job is in progress.
- done_o  out  1  one-cycle pulse with the final write.

## Operation
- States: IDLE, WRITE.
  - IDLE -> WRITE on start_i.
  - WRITE -> IDLE on acceptance of the last beat (row U_dim1, tile W_tiles1).
- On start_i, the block latches U_dim1, W_tiles1 and base.
  - Row counter, tile counter and row pointer are all cleared to 0.
  - The stride is latched as W_tiles1+1.
- acc_ready_o = (state==WRITE) & ~ub_wr_stall_i.
  - It is combinational; acc_valid_i must not depend on it.
- A beat is one cycle with acc_valid_i & acc_ready_o.
- The accumulator delivers tile 0 rows 0..U_dim1, then tile 1, and so on.
- Address of beat (row r, tile t) = base + r*stride + t, taken modulo 2^ADDR_W.
  - No multiplier is used.
  - A row pointer advances by stride on each beat.
  - At the end of a tile the pointer reloads to base + t + 1.
- Row counter is 7 bits and the tile counter is 3 bits.
  - When the row counter equals U_dim1 on a beat, it clears and the tile counter increments.
  - When the tile counter equals W_tiles1 on that beat, the job ends.
- Address wrap: a sum above 2^ADDR_W-1 wraps silently. No error is flagged.
- start_i in WRITE is ignored. The latched configuration is unaffected by changes to the config inputs mid-job.
- acc_valid_i in IDLE is not accepted (acc_ready_o=0).
- ub_wr_stall_i during a beat-pending cycle holds all counters. No write is issued.

## Timing
- Reset values: write_en_o=0, addr_wr_o=0, data_wr_o=0, busy_o=0, done_o=0, acc_ready_o=0; state is IDLE.
- Reset is asynchronous. Asserting rst_i mid-job aborts immediately, with no partial-row write after release.
- Latency from start_i to ready:
  - start_i is sampled at edge N.
  - busy_o=1 and acc_ready_o=1 (if not stalled) from cycle N+1.
- Latency from beat to write:
  - A beat is sampled at edge N.
  - write_en_o=1 with its addr/data in cycle N+1, for exactly one cycle per beat.
- Address, data and write strobe are registered.
- Throughput is one row per cycle with no bubbles, including across tile boundaries.
- done_o is high in the same cycle as the final write_en_o. busy_o falls in that same cycle.
- start_i in the cycle done_o is high is accepted, because the state is already IDLE.
- Write strobes are never issued without a preceding beat.

## Test plan
- Minimal job: U_dim1=0, W_tiles1=0, base=0x100, one beat.
  - Required: a single write at 0x100 one cycle later, done_o coincident, then busy_o=0.
- Strided layout: U_dim1=3, W_tiles1=2, base=0x010, valid always high.
  - Required address sequence: 010,013,016,019, 011,014,017,01A, 012,015,018,01B.
  - 12 consecutive strobes, done_o on the 12th.
- Stall and backpressure: same job as the strided-layout case, with ub_wr_stall_i high for 3 cycles at beat 5 and acc_valid_i low for 2 cycles at beat 9.
  - Required: the same 12 addresses/data in order, no duplicated or lost writes, no strobes during gaps.
- Wrap: base=0xFFE, U_dim1=2, W_tiles1=0.
  - Required addresses: FFE, FFF, 000.
- Ignored start: start_i pulsed mid-job with different config.
  - Required: the job completes with the original config.
  - A start_i on the done_o cycle launches the next job cleanly.
- Reset mid-job: rst_i asserted after beat 4 of 12.
  - Required: all outputs 0 asynchronously, state IDLE.
  - A fresh start_i after release begins at row 0/tile 0 and base.
